leglite_fetch_unit: RTL and testbench

- Instruction-fetch and instruction-register block for the LEGLite multicycle core. It is the producer side of the control interface.
- Fetches 16-bit instructions from instruction memory over a req/ack handshake and latches them in an instruction register (IR).
- Presents the opcode and decoded fields to the control unit, then waits for end-of-instruction before advancing the PC.
- PC update is either sequential or branch-target, depending on the branch result returned by the datapath.

---
 rtl/leglite_fetch_unit.sv | 174 +++++++++++++++++
 tb/tb_leglite_fetch_unit.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/leglite_fetch_unit.sv
// ---------------------------------------------------------------------------
// leglite_fetch_unit
//
// Instruction fetch and instruction register for the LEGLite multicycle core.
// Fetches one 16-bit instruction per pass over a req/ack handshake, holds it
// in the IR, presents decoded fields to the control unit for one DECODE
// cycle, then waits in EXEC for the control unit to finish the instruction
// before advancing the PC (sequentially or to a branch target).
//
// Ports:
//   clock        rising-edge clock
//   reset        synchronous, active-low reset
//   imem_addr    word address to instruction memory (the PC)
//   imem_req     fetch request, high throughout FETCH
//   imem_ack     memory acknowledge, qualifies imem_rdata in the same cycle
//   imem_rdata   instruction word from memory
//   opcode       IR[15:13]
//   field_a      IR[12:10], register A / Rd select
//   field_b      IR[9:7],   register B select
//   field_d      IR[2:0],   register D select
//   imm          IR[9:3] sign-extended to 16 bits
//   op_valid     one-cycle pulse when a new IR is presented (DECODE)
//   exec_done    control unit has completed the current instruction
//   branch       branch control for the current instruction
//   zero         ALU zero flag
//   halt         stop fetching after the current instruction
//   pc           current program counter
//   busy         high in every state except IDLE and HALTED
//   fetch_error  sticky flag, set when memory fails to acknowledge in time
// ---------------------------------------------------------------------------
module leglite_fetch_unit #(
    parameter int unsigned          PC_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0]  RESET_PC = '0,
    parameter int unsigned          MAX_WAIT = 15
) (
    input  logic                clock,
    input  logic                reset,
    output logic [PC_WIDTH-1:0] imem_addr,
    output logic                imem_req,
    input  logic                imem_ack,
    input  logic [15:0]         imem_rdata,
    output logic [2:0]          opcode,
    output logic [2:0]          field_a,
    output logic [2:0]          field_b,
    output logic [2:0]          field_d,
    output logic [15:0]         imm,
    output logic                op_valid,
    input  logic                exec_done,
    input  logic                branch,
    input  logic                zero,
    input  logic                halt,
    output logic [PC_WIDTH-1:0] pc,
    output logic                busy,
    output logic                fetch_error
);

    localparam int unsigned CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;

    // Waiting cycle on which an un-acknowledged fetch gives up.
    localparam logic [CW-1:0] LAST_WAIT = CW'(MAX_WAIT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        HALTED = 3'd4
    } state_t;

    state_t              state, state_next;
    logic [15:0]         ir, ir_next;
    logic [PC_WIDTH-1:0] pc_next;
    logic [CW-1:0]       wait_cnt, wait_next;
    logic                fetch_error_next;
    logic                halt_pending, halt_pending_next;
    logic [PC_WIDTH-1:0] imm_pc;

    // Branch offset: 7-bit signed immediate resized to the PC width, so the
    // add below wraps modulo 2^PC_WIDTH.
    assign imm_pc = PC_WIDTH'($signed(ir[9:3]));

    // Combinational decode of the IR; stable until the next IR load.
    assign opcode  = ir[15:13];
    assign field_a = ir[12:10];
    assign field_b = ir[9:7];
    assign field_d = ir[2:0];
    assign imm     = 16'($signed(ir[9:3]));

    assign imem_req  = (state == FETCH);
    assign imem_addr = pc;
    assign op_valid  = (state == DECODE);
    assign busy      = (state != IDLE) && (state != HALTED);

    // Next-state and next-register logic.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch can be inferred.
        state_next        = state;
        pc_next           = pc;
        ir_next           = ir;
        wait_next         = wait_cnt;
        fetch_error_next  = fetch_error;
        halt_pending_next = halt_pending;

        unique case (state)
            IDLE: begin
                state_next = FETCH;
            end

            FETCH: begin
                if (halt) halt_pending_next = 1'b1;
                if (imem_ack) begin
                    ir_next    = imem_rdata;
                    wait_next  = '0;
                    state_next = DECODE;
                end else if (wait_cnt == LAST_WAIT) begin
                    // This is the MAX_WAIT-th cycle without an ack.
                    fetch_error_next = 1'b1;
                    wait_next        = '0;
                    state_next       = HALTED;
                end else begin
                    wait_next = wait_cnt + CW'(1);
                end
            end

            DECODE: begin
                if (halt) halt_pending_next = 1'b1;
                state_next = EXEC;
            end

            EXEC: begin
                if (halt) halt_pending_next = 1'b1;
                if (exec_done) begin
                    if (branch && zero) pc_next = pc + imm_pc;
                    else                pc_next = pc + PC_WIDTH'(1);
                    // halt on the exec_done cycle counts as well as one
                    // latched earlier in this instruction.
                    state_next        = (halt || halt_pending) ? HALTED : FETCH;
                    halt_pending_next = 1'b0;
                end
            end

            HALTED: begin
                state_next = HALTED;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and register update; reset overrides every state.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so all
        // registers update together from values sampled before the edge.
        if (!reset) begin
            state        <= IDLE;
            pc           <= RESET_PC;
            ir           <= 16'h0000;
            wait_cnt     <= '0;
            fetch_error  <= 1'b0;
            halt_pending <= 1'b0;
        end else begin
            state        <= state_next;
            pc           <= pc_next;
            ir           <= ir_next;
            wait_cnt     <= wait_next;
            fetch_error  <= fetch_error_next;
            halt_pending <= halt_pending_next;
        end
    end

endmodule

// File: tb/tb_leglite_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_leglite_fetch_unit
//
// Directed bench for leglite_fetch_unit. Two instances share every input:
// "dut" starts at PC 0, "dut_w" starts at PC 16'hFFFF to exercise PC wrap.
// Inputs change 1 time unit after a rising edge; outputs are sampled there.
// ---------------------------------------------------------------------------
module tb_leglite_fetch_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        exec_done;
    logic        branch;
    logic        zero;
    logic        halt;

    logic [15:0] imem_addr, pc, imm;
    logic        imem_req, op_valid, busy, fetch_error;
    logic [2:0]  opcode, field_a, field_b, field_d;

    logic [15:0] w_imem_addr, w_pc, w_imm;
    logic        w_imem_req, w_op_valid, w_busy, w_fetch_error;
    logic [2:0]  w_opcode, w_field_a, w_field_b, w_field_d;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    leglite_fetch_unit #(.PC_WIDTH(16), .RESET_PC(16'h0000), .MAX_WAIT(15)) dut (
        .clock(clock), .reset(reset),
        .imem_addr(imem_addr), .imem_req(imem_req), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata),
        .opcode(opcode), .field_a(field_a), .field_b(field_b), .field_d(field_d),
        .imm(imm), .op_valid(op_valid),
        .exec_done(exec_done), .branch(branch), .zero(zero), .halt(halt),
        .pc(pc), .busy(busy), .fetch_error(fetch_error)
    );

    leglite_fetch_unit #(.PC_WIDTH(16), .RESET_PC(16'hFFFF), .MAX_WAIT(15)) dut_w (
        .clock(clock), .reset(reset),
        .imem_addr(w_imem_addr), .imem_req(w_imem_req), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata),
        .opcode(w_opcode), .field_a(w_field_a), .field_b(w_field_b), .field_d(w_field_d),
        .imm(w_imm), .op_valid(w_op_valid),
        .exec_done(exec_done), .branch(branch), .zero(zero), .halt(halt),
        .pc(w_pc), .busy(w_busy), .fetch_error(w_fetch_error)
    );

    task automatic check(input string tag, input logic [15:0] observed,
                         input logic [15:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Called while in FETCH; ack arrives after 'delay' wait cycles.
    // Returns in DECODE.
    task automatic fetch(input logic [15:0] addr, input logic [15:0] word,
                         input int delay, input logic [2:0] prev_op);
        for (int i = 0; i < delay; i++) begin
            check("wait_req",  16'(imem_req), 16'h1);
            check("wait_addr", imem_addr, addr);
            check("wait_ir",   16'(opcode), 16'(prev_op));
            tick();
        end
        check("fetch_req",  16'(imem_req), 16'h1);
        check("fetch_addr", imem_addr, addr);
        imem_ack   = 1'b1;
        imem_rdata = word;
        tick();
        imem_ack   = 1'b0;
        imem_rdata = 16'h0000;
        check("decode_op_valid", 16'(op_valid), 16'h1);
        check("decode_opcode",   16'(opcode), 16'(word[15:13]));
        check("decode_req",      16'(imem_req), 16'h0);
    endtask

    // Called in DECODE; exec_done arrives 'delay' cycles after entering EXEC.
    task automatic execute(input logic br, input logic z, input int delay);
        tick();
        check("exec_op_valid", 16'(op_valid), 16'h0);
        check("exec_busy",     16'(busy), 16'h1);
        for (int i = 0; i < delay; i++) tick();
        exec_done = 1'b1;
        branch    = br;
        zero      = z;
        tick();
        exec_done = 1'b0;
        branch    = 1'b0;
        zero      = 1'b0;
    endtask

    initial begin
        reset      = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = 16'h0000;
        exec_done  = 1'b0;
        branch     = 1'b0;
        zero       = 1'b0;
        halt       = 1'b0;

        // Reset held for two edges.
        tick();
        tick();
        check("rst_pc",        pc, 16'h0000);
        check("rst_w_pc",      w_pc, 16'hFFFF);
        check("rst_op_valid",  16'(op_valid), 16'h0);
        check("rst_req",       16'(imem_req), 16'h0);
        check("rst_error",     16'(fetch_error), 16'h0);
        check("rst_busy",      16'(busy), 16'h0);
        check("rst_opcode",    16'(opcode), 16'h0);
        check("rst_imm",       imm, 16'h0000);

        // IDLE -> FETCH one edge after release.
        reset = 1'b1;
        tick();
        check("w_fetch_addr", w_imem_addr, 16'hFFFF);

        // Sequential fetch of 0000 and C00A.
        fetch(16'h0000, 16'h0000, 0, 3'd0);
        execute(1'b0, 1'b0, 0);
        check("seq_pc1", pc, 16'h0001);
        check("wrap_pc", w_pc, 16'h0000);
        fetch(16'h0001, 16'hC00A, 0, 3'd0);
        check("seq_opcode6", 16'(opcode), 16'h0006);
        execute(1'b0, 1'b0, 0);
        check("seq_pc2",   pc, 16'h0002);
        check("wrap_pc1",  w_pc, 16'h0001);

        // Advance to pc=5 with plain instructions.
        for (int a = 2; a < 5; a++) begin
            fetch(16'(a), 16'h2000, 0, (a == 2) ? 3'd6 : 3'd1);
            execute(1'b0, 1'b0, 0);
        end
        check("pc5", pc, 16'h0005);

        // Taken branch backwards by one.
        fetch(16'h0005, 16'hA3F8, 0, 3'd1);
        check("br_imm",   imm, 16'hFFFF);
        check("br_fa",    16'(field_a), 16'h0);
        check("br_fb",    16'(field_b), 16'h7);
        check("br_fd",    16'(field_d), 16'h0);
        execute(1'b1, 1'b1, 0);
        check("br_taken_pc", pc, 16'h0004);

        // branch without zero: sequential.
        fetch(16'h0004, 16'h2000, 0, 3'd5);
        execute(1'b0, 1'b1, 0);
        fetch(16'h0005, 16'hA3F8, 0, 3'd1);
        execute(1'b1, 1'b0, 0);
        check("br_not_taken_addr", imem_addr, 16'h0006);

        // Three wait states, then slow exec with a stray ack in EXEC.
        fetch(16'h0006, 16'h4000, 3, 3'd5);
        tick();
        imem_ack   = 1'b1;
        imem_rdata = 16'hFFFF;
        tick();
        imem_ack   = 1'b0;
        imem_rdata = 16'h0000;
        check("exec_ack_ignored", 16'(opcode), 16'h0002);
        check("exec_wait_pc",     pc, 16'h0006);
        exec_done = 1'b1;
        tick();
        exec_done = 1'b0;
        check("slow_exec_pc", pc, 16'h0007);

        // Reset in the middle of EXEC at pc=7.
        fetch(16'h0007, 16'h2000, 0, 3'd2);
        tick();
        reset = 1'b0;
        tick();
        check("mid_rst_pc",       pc, 16'h0000);
        check("mid_rst_op_valid", 16'(op_valid), 16'h0);
        check("mid_rst_error",    16'(fetch_error), 16'h0);
        check("mid_rst_req",      16'(imem_req), 16'h0);
        reset = 1'b1;
        tick();
        check("restart_req",  16'(imem_req), 16'h1);
        check("restart_addr", imem_addr, 16'h0000);

        // Halt pulsed during DECODE of the instruction at pc=3.
        for (int a = 0; a < 3; a++) begin
            fetch(16'(a), 16'h2000, 0, (a == 0) ? 3'd0 : 3'd1);
            execute(1'b0, 1'b0, 0);
        end
        fetch(16'h0003, 16'h2000, 0, 3'd1);
        halt = 1'b1;
        tick();
        halt = 1'b0;
        check("halt_in_exec_busy", 16'(busy), 16'h1);
        exec_done = 1'b1;
        tick();
        exec_done = 1'b0;
        check("halt_pc",   pc, 16'h0004);
        check("halt_busy", 16'(busy), 16'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("halted_req", 16'(imem_req), 16'h0);
        end
        exec_done = 1'b1;
        tick();
        exec_done = 1'b0;
        check("halted_exec_done_ignored", pc, 16'h0004);

        // Fetch timeout: no ack for MAX_WAIT cycles.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        check("to_req_first", 16'(imem_req), 16'h1);
        for (int i = 1; i < 15; i++) begin
            tick();
            check("to_req_waiting",   16'(imem_req), 16'h1);
            check("to_error_waiting", 16'(fetch_error), 16'h0);
        end
        tick();
        check("to_error", 16'(fetch_error), 16'h1);
        check("to_busy",  16'(busy), 16'h0);
        check("to_req",   16'(imem_req), 16'h0);
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        check("to_sticky",        16'(fetch_error), 16'h1);
        check("to_halted_opcode", 16'(opcode), 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
